cd40147_bcd_decoder_seq: RTL

Sequential companion to the 10-line to 4-line BCD priority encoder. It accepts 4-bit BCD codes through a valid/ready handshake and drives the matching one of ten output lines high. Each line is held for a programmable pulse time, followed by a programmable all-low gap. The block treats 4'b1111, the encoder's "no line active" code, as idle. It flags the unused codes 1010..1110 as errors and counts them. It sits downstream of the encoder, or of any BCD source, to recreate line-level strobes.

---
 rtl/cd40147_bcd_decoder_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cd40147_bcd_decoder_seq.sv
// Sequential BCD-to-decimal line driver: each accepted digit becomes a timed one-hot strobe,
// followed by an all-low gap. Unused codes 1010..1110 are flagged and counted.
module cd40147_bcd_decoder_seq #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_bcd,
    output logic             in_ready,
    output logic [9:0]       o,
    output logic             busy,
    output logic [3:0]       last_digit,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    input  logic             clr_err
);

    localparam int unsigned MaxPg  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCnt = (MaxPg > 2) ? MaxPg : 2;
    localparam int unsigned CntW   = $clog2(MaxCnt);
    localparam int unsigned GapLd  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CntW-1:0]  PulseLoad = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0]  GapLoad   = CntW'(GapLd);
    localparam logic [ERR_W-1:0] ErrMax    = {ERR_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [9:0]       o_q, o_d;
    logic             busy_q, busy_d;
    logic [3:0]       last_q, last_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] errc_q, errc_d, errc_base;

    logic accept, digit_acc, bad_acc;

    assign in_ready  = (state_q == StIdle);
    assign accept    = in_valid && in_ready;
    assign digit_acc = accept && (in_bcd <= 4'd9);
    // 1111 is the encoder's "no line" code and is swallowed silently
    assign bad_acc   = accept && (in_bcd >= 4'd10) && (in_bcd != 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            o_q     <= '0;
            busy_q  <= 1'b0;
            last_q  <= '0;
            err_q   <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            err_q   <= err_d;
            errc_q  <= errc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (digit_acc) begin
                    state_d = StDrive;
                    cnt_d   = PulseLoad;
                end
            end
            StDrive: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (GAP_CYCLES > 0) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_d    = o_q;
        last_d = last_q;
        err_d  = bad_acc;
        busy_d = (state_d != StIdle);
        if (digit_acc) begin
            o_d    = 10'd1 << in_bcd;
            last_d = in_bcd;
        end else if (state_q == StDrive && cnt_q == '0) begin
            o_d = '0;
        end
        // Clear takes effect first, so a same-cycle error lands on a fresh count
        errc_base = clr_err ? '0 : errc_q;
        if (bad_acc && errc_base != ErrMax) begin
            errc_d = errc_base + ERR_W'(1);
        end else begin
            errc_d = errc_base;
        end
    end

    assign o          = o_q;
    assign busy       = busy_q;
    assign last_digit = last_q;
    assign err        = err_q;
    assign err_count  = errc_q;

endmodule
